// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Builds 32-bit MIPS instruction words from symbolic requests (a mnemonic
// index plus raw register/immediate/target fields). It queues them in a
// small FIFO and streams them into instruction memory through a write port
// with an auto-incrementing word address. The boot/test loader uses it to
// lay down programs.
//
// Parameters
//   DEPTH   FIFO entries (power of two, >= 2)
//   ADDR_W  instruction-memory word-address width
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   inValid      request valid
//   inReady      encoder can accept a request (FIFO not full)
//   mnem         mnemonic index, 0..38 legal
//   rs/rt/rd     register fields
//   shamt        shift amount
//   imm          immediate / branch offset
//   target       jump target
//   loadAddr     load write address from baseAddr
//   baseAddr     new write address
//   flush        discard FIFO contents
//   clrErr       clear illegalFlag
//   memWrEn      write request to instruction memory
//   memReady     memory accepts the write this cycle
//   memAddr      word address of the current write
//   memData      instruction word of the current write
//   illegalFlag  sticky: an unmapped mnemonic was accepted
//   wordCount    words written since reset, saturating at 0xFFFF
//   empty        FIFO empty
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic [5:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              loadAddr,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic              flush,
    input  logic              clrErr,
    output logic              memWrEn,
    input  logic              memReady,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memData,
    output logic              illegalFlag,
    output logic [15:0]       wordCount,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W:0]    PTR_ONE  = (PTR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [15:0]       COUNT_MAX = 16'hFFFF;

    // Instruction format selected by the mnemonic.
    typedef enum logic [1:0] {
        KIND_ILLEGAL,
        KIND_R,
        KIND_I,
        KIND_J
    } kind_t;

    kind_t       kind;
    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic [31:0] encoded;

    // FIFO storage and pointers. Pointers carry one extra wrap bit so that
    // full and empty can be told apart when the index bits match.
    logic [31:0]      storage [DEPTH];
    logic [PTR_W:0]   head_ptr;
    logic [PTR_W:0]   tail_ptr;
    logic             full;
    logic             accept;
    logic             legal;
    logic             push;
    logic             pop;

    logic [ADDR_W-1:0] addr_reg;
    logic [15:0]       count_reg;
    logic              illegal_reg;

    // Mnemonic lookup: picks the format and the funct (R-type) or opcode
    // (I/J-type). Anything above 38 is illegal.
    always_comb begin
        kind   = KIND_ILLEGAL;
        funct  = 6'b000000;
        opcode = 6'b000000;
        case (mnem)
            6'd0:  begin kind = KIND_R; funct = 6'b100000; end // add
            6'd1:  begin kind = KIND_R; funct = 6'b100010; end // sub
            6'd2:  begin kind = KIND_R; funct = 6'b100001; end // addu
            6'd3:  begin kind = KIND_R; funct = 6'b100011; end // subu
            6'd4:  begin kind = KIND_R; funct = 6'b100100; end // and
            6'd5:  begin kind = KIND_R; funct = 6'b100101; end // or
            6'd6:  begin kind = KIND_R; funct = 6'b100110; end // xor
            6'd7:  begin kind = KIND_R; funct = 6'b000000; end // sll
            6'd8:  begin kind = KIND_R; funct = 6'b000010; end // srl
            6'd9:  begin kind = KIND_R; funct = 6'b000011; end // sra
            6'd10: begin kind = KIND_R; funct = 6'b101010; end // slt
            6'd11: begin kind = KIND_R; funct = 6'b011000; end // mul
            6'd12: begin kind = KIND_R; funct = 6'b011001; end // madd
            6'd13: begin kind = KIND_R; funct = 6'b011010; end // maddu
            6'd14: begin kind = KIND_R; funct = 6'b001000; end // jr
            6'd15: begin kind = KIND_R; funct = 6'b110000; end // add.s
            6'd16: begin kind = KIND_R; funct = 6'b110001; end // sub.s
            6'd17: begin kind = KIND_R; funct = 6'b110010; end // c.eq.s
            6'd18: begin kind = KIND_R; funct = 6'b110011; end // c.le.s
            6'd19: begin kind = KIND_R; funct = 6'b110100; end // c.lt.s
            6'd20: begin kind = KIND_R; funct = 6'b110101; end // c.ge.s
            6'd21: begin kind = KIND_R; funct = 6'b110110; end // c.gt.s
            6'd22: begin kind = KIND_R; funct = 6'b011110; end // mov.s
            6'd23: begin kind = KIND_I; opcode = 6'b001000; end // addi
            6'd24: begin kind = KIND_I; opcode = 6'b001001; end // addiu
            6'd25: begin kind = KIND_I; opcode = 6'b000100; end // beq
            6'd26: begin kind = KIND_I; opcode = 6'b000101; end // bne
            6'd27: begin kind = KIND_I; opcode = 6'b000110; end // bgt
            6'd28: begin kind = KIND_I; opcode = 6'b000111; end // bgte
            6'd29: begin kind = KIND_I; opcode = 6'b001100; end // ble
            6'd30: begin kind = KIND_I; opcode = 6'b001101; end // bleq
            6'd31: begin kind = KIND_I; opcode = 6'b010011; end // bgtu
            6'd32: begin kind = KIND_I; opcode = 6'b100011; end // lw
            6'd33: begin kind = KIND_I; opcode = 6'b101011; end // sw
            6'd34: begin kind = KIND_I; opcode = 6'b001111; end // lui
            6'd35: begin kind = KIND_I; opcode = 6'b001010; end // slti
            6'd36: begin kind = KIND_I; opcode = 6'b001011; end // seq
            6'd37: begin kind = KIND_J; opcode = 6'b000010; end // j
            6'd38: begin kind = KIND_J; opcode = 6'b000011; end // jal
            default: begin kind = KIND_ILLEGAL; end
        endcase
    end

    // Word assembly. Fields that a format does not use are passed through
    // verbatim rather than zeroed, so the loader sees exactly what it sent.
    always_comb begin
        encoded = 32'd0;
        case (kind)
            KIND_R:  encoded = {6'b000000, rs, rt, rd, shamt, funct};
            KIND_I:  encoded = {opcode, rs, rt, imm};
            KIND_J:  encoded = {opcode, target};
            default: encoded = 32'd0;
        endcase
    end

    // Handshake qualifiers. An illegal mnemonic still completes the input
    // handshake but never reaches the FIFO; a flush discards any push.
    assign full    = (head_ptr[PTR_W] != tail_ptr[PTR_W]) &&
                     (head_ptr[PTR_W-1:0] == tail_ptr[PTR_W-1:0]);
    assign empty   = (head_ptr == tail_ptr);
    assign inReady = !full;
    assign memWrEn = !empty;
    assign legal   = (kind != KIND_ILLEGAL);
    assign accept  = inValid && inReady;
    assign push    = accept && legal && !flush;
    assign pop     = memWrEn && memReady;

    // FIFO. Reset clears the storage so the head reads as zero afterwards.
    // Flush moves the tail onto the post-pop head, which lets a pop on the
    // same edge complete while everything behind it is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= 32'd0;
            end
        end else begin
            if (pop) begin
                head_ptr <= head_ptr + PTR_ONE;
            end
            if (flush) begin
                tail_ptr <= head_ptr + {{PTR_W{1'b0}}, pop};
            end else if (push) begin
                storage[tail_ptr[PTR_W-1:0]] <= encoded;
                tail_ptr <= tail_ptr + PTR_ONE;
            end
        end
    end

    // Write address. A load wins over the post-pop increment: the popped
    // word goes out at the old address and the next one lands at baseAddr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg <= '0;
        end else if (loadAddr) begin
            addr_reg <= baseAddr;
        end else if (pop) begin
            addr_reg <= addr_reg + ADDR_ONE;
        end
    end

    // Saturating count of completed memory writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= 16'd0;
        end else if (pop && (count_reg != COUNT_MAX)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    // Sticky illegal-mnemonic flag; a new illegal request beats clrErr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_reg <= 1'b0;
        end else if (accept && !legal) begin
            illegal_reg <= 1'b1;
        end else if (clrErr) begin
            illegal_reg <= 1'b0;
        end
    end

    assign memData     = storage[head_ptr[PTR_W-1:0]];
    assign memAddr     = addr_reg;
    assign wordCount   = count_reg;
    assign illegalFlag = illegal_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed scenarios followed by a randomized run. A queue-based reference
// model (list of pending words, address, count, flag) predicts every
// registered output each cycle; the encoding reference is built from
// opcode/funct tables with shifts and ORs.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              inValid;
    logic              inReady;
    logic [5:0]        mnem;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              loadAddr;
    logic [ADDR_W-1:0] baseAddr;
    logic              flush;
    logic              clrErr;
    logic              memWrEn;
    logic              memReady;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memData;
    logic              illegalFlag;
    logic [15:0]       wordCount;
    logic              empty;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
        .target(target), .loadAddr(loadAddr), .baseAddr(baseAddr),
        .flush(flush), .clrErr(clrErr), .memWrEn(memWrEn),
        .memReady(memReady), .memAddr(memAddr), .memData(memData),
        .illegalFlag(illegalFlag), .wordCount(wordCount), .empty(empty)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model state
    logic [31:0] modelQ[$];
    int          modelAddr;
    int          modelCount;
    bit          modelFlag;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t dutWrites[$];

    int rFunct [23] = '{'h20, 'h22, 'h21, 'h23, 'h24, 'h25, 'h26, 'h00,
                        'h02, 'h03, 'h2A, 'h18, 'h19, 'h1A, 'h08, 'h30,
                        'h31, 'h32, 'h33, 'h34, 'h35, 'h36, 'h1E};
    int iOp [14]    = '{'h08, 'h09, 'h04, 'h05, 'h06, 'h07, 'h0C, 'h0D,
                        'h13, 'h23, 'h2B, 'h0F, 'h0A, 'h0B};
    int jOp [2]     = '{'h02, 'h03};

    logic [31:0] expWords [5];

    function automatic logic [31:0] refEncode(input int m,
                                              input logic [4:0] f_rs,
                                              input logic [4:0] f_rt,
                                              input logic [4:0] f_rd,
                                              input logic [4:0] f_sh,
                                              input logic [15:0] f_imm,
                                              input logic [25:0] f_tgt);
        if (m <= 22)
            return (32'(f_rs) << 21) | (32'(f_rt) << 16) | (32'(f_rd) << 11) |
                   (32'(f_sh) << 6) | 32'(rFunct[m]);
        else if (m <= 36)
            return (32'(iOp[m-23]) << 26) | (32'(f_rs) << 21) |
                   (32'(f_rt) << 16) | 32'(f_imm);
        else if (m <= 38)
            return (32'(jOp[m-37]) << 26) | 32'(f_tgt);
        else
            return 32'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkWrite(input string tag, input int idx,
                              input logic [31:0] expAddr, input logic [31:0] expData);
        logic [31:0] a;
        logic [31:0] d;
        a = 32'hDEAD_BEEF;
        d = 32'hDEAD_BEEF;
        if (idx < dutWrites.size()) begin
            a = dutWrites[idx].addr;
            d = dutWrites[idx].data;
        end
        checkOutput({tag, ".addr"}, a, expAddr);
        checkOutput({tag, ".data"}, d, expData);
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelAddr  = 0;
        modelCount = 0;
        modelFlag  = 1'b0;
    endtask

    task automatic setReq(input int m, input int f_rs, input int f_rt, input int f_rd,
                          input int f_sh, input int f_imm, input int f_tgt);
        mnem   = 6'(m);
        rs     = 5'(f_rs);
        rt     = 5'(f_rt);
        rd     = 5'(f_rd);
        shamt  = 5'(f_sh);
        imm    = 16'(f_imm);
        target = 26'(f_tgt);
    endtask

    task automatic idleInputs();
        rst_n    = 1'b1;
        inValid  = 1'b0;
        loadAddr = 1'b0;
        baseAddr = '0;
        flush    = 1'b0;
        clrErr   = 1'b0;
        memReady = 1'b1;
        setReq(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Checks the registered outputs against the model, logs any DUT write
    // handshake, advances the model by one edge and clocks the DUT.
    task automatic applyStimulus();
        bit pop;
        bit acc;
        bit legal;
        checkOutput("inReady", 32'(inReady), 32'(modelQ.size() < DEPTH));
        checkOutput("memWrEn", 32'(memWrEn), 32'(modelQ.size() > 0));
        checkOutput("empty", 32'(empty), 32'(modelQ.size() == 0));
        checkOutput("memAddr", 32'(memAddr), 32'(modelAddr));
        checkOutput("wordCount", 32'(wordCount), 32'(modelCount));
        checkOutput("illegalFlag", 32'(illegalFlag), 32'(modelFlag));
        if (modelQ.size() > 0)
            checkOutput("memData", memData, modelQ[0]);

        if (rst_n === 1'b1 && memWrEn === 1'b1 && memReady === 1'b1)
            dutWrites.push_back('{32'(memAddr), memData, cycle});

        pop   = (modelQ.size() > 0) && memReady;
        acc   = inValid && (modelQ.size() < DEPTH);
        legal = (int'(mnem) <= 38);
        if (!rst_n) begin
            modelReset();
        end else begin
            if (pop) begin
                void'(modelQ.pop_front());
                if (modelCount < 65535) modelCount++;
            end
            if (loadAddr) modelAddr = int'(baseAddr);
            else if (pop) modelAddr = (modelAddr + 1) % (1 << ADDR_W);
            if (flush) modelQ.delete();
            else if (acc && legal)
                modelQ.push_back(refEncode(int'(mnem), rs, rt, rd, shamt, imm, target));
            if (acc && !legal) modelFlag = 1'b1;
            else if (clrErr) modelFlag = 1'b0;
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        dutWrites.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        idleInputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        applyStimulus();
        rst_n = 1'b1;

        // Reset state
        checkOutput("rst.memData", memData, 32'h0);
        checkOutput("rst.empty", 32'(empty), 32'd1);
        checkOutput("rst.inReady", 32'(inReady), 32'd1);
        checkOutput("rst.memWrEn", 32'(memWrEn), 32'd0);
        checkOutput("rst.memAddr", 32'(memAddr), 32'd0);
        checkOutput("rst.wordCount", 32'(wordCount), 32'd0);

        // Single add: presented the cycle after acceptance
        setReq(0, 1, 2, 3, 0, 0, 0);
        inValid = 1'b1;
        applyStimulus();
        inValid = 1'b0;
        checkOutput("add.memWrEn", 32'(memWrEn), 32'd1);
        checkOutput("add.memAddr", 32'(memAddr), 32'd0);
        checkOutput("add.memData", memData, 32'h0022_1820);
        applyStimulus();
        checkOutput("add.wordCount", 32'(wordCount), 32'd1);

        // Back-to-back stream after a fresh reset
        doReset();
        inValid = 1'b1;
        setReq(23, 1, 2, 0, 0, 5, 0);     applyStimulus();
        setReq(32, 2, 4, 0, 0, 8, 0);     applyStimulus();
        setReq(37, 0, 0, 0, 0, 0, 'h100); applyStimulus();
        inValid = 1'b0;
        repeat (3) applyStimulus();
        checkWrite("stream0", 0, 32'd0, 32'h2022_0005);
        checkWrite("stream1", 1, 32'd1, 32'h8C44_0008);
        checkWrite("stream2", 2, 32'd2, 32'h0800_0100);
        checkOutput("stream.count", 32'(dutWrites.size()), 32'd3);
        if (dutWrites.size() == 3) begin
            checkOutput("stream.gap01", 32'(dutWrites[1].cyc - dutWrites[0].cyc), 32'd1);
            checkOutput("stream.gap12", 32'(dutWrites[2].cyc - dutWrites[1].cyc), 32'd1);
        end

        // Back-pressure: fill while memory stalls
        doReset();
        memReady = 1'b0;
        inValid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: setReq(1, 3, 4, 5, 0, 0, 0);
                1: setReq(24, 7, 8, 0, 0, 'hFFFF, 0);
                2: setReq(33, 29, 31, 0, 0, 'h0010, 0);
                3: setReq(38, 0, 0, 0, 0, 0, 'h3FF_FFFF);
                default: setReq(12, 9, 10, 11, 17, 0, 0);
            endcase
            expWords[i] = refEncode(int'(mnem), rs, rt, rd, shamt, imm, target);
            if (i < 4) applyStimulus();
        end
        checkOutput("bp.inReady", 32'(inReady), 32'd0);
        applyStimulus();
        applyStimulus();
        checkOutput("bp.memData", memData, expWords[0]);
        checkOutput("bp.memAddr", 32'(memAddr), 32'd0);
        memReady = 1'b1;
        applyStimulus();
        applyStimulus();
        inValid = 1'b0;
        repeat (5) applyStimulus();
        for (int i = 0; i < 5; i++)
            checkWrite($sformatf("bp%0d", i), i, 32'(i), expWords[i]);
        checkOutput("bp.count", 32'(dutWrites.size()), 32'd5);

        // Illegal mnemonics and the sticky flag
        doReset();
        setReq(50, 1, 1, 1, 1, 1, 1);
        inValid = 1'b1;
        checkOutput("ill.inReady", 32'(inReady), 32'd1);
        applyStimulus();
        inValid = 1'b0;
        checkOutput("ill.flag", 32'(illegalFlag), 32'd1);
        checkOutput("ill.noPush", 32'(memWrEn), 32'd0);
        clrErr = 1'b1;
        applyStimulus();
        clrErr = 1'b0;
        checkOutput("ill.cleared", 32'(illegalFlag), 32'd0);
        inValid = 1'b1;
        clrErr  = 1'b1;
        applyStimulus();
        clrErr = 1'b0;
        setReq(39, 0, 0, 0, 0, 0, 0);
        applyStimulus();
        setReq(38, 0, 0, 0, 0, 0, 'h55);
        applyStimulus();
        inValid = 1'b0;
        checkOutput("ill.wins", 32'(illegalFlag), 32'd1);
        checkOutput("ill.mnem38", memData, 32'h0C00_0055);
        applyStimulus();

        // Address load and wrap
        doReset();
        loadAddr = 1'b1;
        baseAddr = 10'h3FF;
        applyStimulus();
        loadAddr = 1'b0;
        inValid  = 1'b1;
        setReq(5, 1, 2, 3, 0, 0, 0);  applyStimulus();
        setReq(6, 4, 5, 6, 0, 0, 0);  applyStimulus();
        inValid = 1'b0;
        repeat (3) applyStimulus();
        checkWrite("wrap0", 0, 32'h3FF, refEncode(5, 1, 2, 3, 0, 0, 0));
        checkWrite("wrap1", 1, 32'h000, refEncode(6, 4, 5, 6, 0, 0, 0));
        dutWrites.delete();
        memReady = 1'b0;
        inValid  = 1'b1;
        setReq(34, 0, 9, 0, 0, 'h1234, 0); applyStimulus();
        setReq(35, 3, 9, 0, 0, 'h0042, 0); applyStimulus();
        inValid  = 1'b0;
        memReady = 1'b1;
        loadAddr = 1'b1;
        baseAddr = 10'h123;
        applyStimulus();
        loadAddr = 1'b0;
        repeat (2) applyStimulus();
        checkWrite("ld0", 0, 32'h001, refEncode(34, 0, 9, 0, 0, 'h1234, 0));
        checkWrite("ld1", 1, 32'h123, refEncode(35, 3, 9, 0, 0, 'h0042, 0));

        // Flush with a simultaneous pop and push
        doReset();
        memReady = 1'b0;
        inValid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setReq(25 + i, i, i + 1, 0, 0, i * 3, 0);
            applyStimulus();
        end
        memReady = 1'b1;
        flush    = 1'b1;
        setReq(2, 7, 7, 7, 7, 0, 0);
        applyStimulus();
        flush   = 1'b0;
        inValid = 1'b0;
        checkOutput("flush.empty", 32'(empty), 32'd1);
        checkOutput("flush.memWrEn", 32'(memWrEn), 32'd0);
        applyStimulus();
        checkOutput("flush.writes", 32'(dutWrites.size()), 32'd1);
        checkWrite("flush0", 0, 32'd0, refEncode(25, 0, 1, 0, 0, 0, 0));

        // Reset in the middle of a stream
        inValid = 1'b1;
        setReq(10, 1, 2, 3, 0, 0, 0);
        repeat (3) applyStimulus();
        rst_n = 1'b0;
        applyStimulus();
        rst_n   = 1'b1;
        inValid = 1'b0;
        checkOutput("midrst.empty", 32'(empty), 32'd1);
        checkOutput("midrst.memAddr", 32'(memAddr), 32'd0);
        checkOutput("midrst.wordCount", 32'(wordCount), 32'd0);
        checkOutput("midrst.memWrEn", 32'(memWrEn), 32'd0);
        applyStimulus();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst_n    = ($urandom_range(63, 0) != 0);
            inValid  = ($urandom_range(3, 0) != 0);
            if ($urandom_range(7, 0) == 0)
                mnem = 6'($urandom_range(63, 39));
            else
                mnem = 6'($urandom_range(38, 0));
            rs       = 5'($urandom);
            rt       = 5'($urandom);
            rd       = 5'($urandom);
            shamt    = 5'($urandom);
            imm      = 16'($urandom);
            target   = 26'($urandom);
            memReady = ($urandom_range(2, 0) != 0);
            flush    = ($urandom_range(15, 0) == 0);
            clrErr   = ($urandom_range(7, 0) == 0);
            loadAddr = ($urandom_range(15, 0) == 0);
            baseAddr = ($urandom_range(1, 0) == 0) ? 10'($urandom_range(1023, 1020))
                                                  : 10'($urandom);
            applyStimulus();
        end
        idleInputs();
        repeat (DEPTH + 1) applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
